// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// IF-stage lookup is combinational from registered state; EX-stage updates and counters commit on clk.
module btb_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             hit,
    output logic             predict_taken,
    output logic [XLEN-1:0]  predict_target,
    input  logic             upd_en,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic             upd_is_jump,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_mispredict,
    input  logic             flush_all,
    output logic [CNT_W-1:0] cnt_updates,
    output logic [CNT_W-1:0] cnt_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        STRONG_T  = 2'b10,
        WEAK_T    = 2'b11
    } ctrState_e;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    ctrState_e          state_q  [ENTRIES];
    logic [CNT_W-1:0]   cntUpdates_q;
    logic [CNT_W-1:0]   cntMispredicts_q;

    logic [IDX_W-1:0] lookupIdx;
    logic [TAG_W-1:0] lookupTag;
    logic [IDX_W-1:0] updIdx;
    logic [TAG_W-1:0] updTag;
    logic             updHit;
    logic             updWrite;
    ctrState_e        updState_d;
    logic [XLEN-1:0]  updTarget_d;
    logic [CNT_W-1:0] cntUpdates_d;
    logic [CNT_W-1:0] cntMispredicts_d;
    logic             unusedPcBits;

    assign lookupIdx = lookup_pc[IDX_W+1:2];
    assign lookupTag = lookup_pc[XLEN-1:IDX_W+2];
    assign updIdx    = upd_pc[IDX_W+1:2];
    assign updTag    = upd_pc[XLEN-1:IDX_W+2];
    assign unusedPcBits = ^upd_pc[1:0];

    // No write bypass: a same-cycle update is only visible from the next cycle.
    assign hit            = valid_q[lookupIdx] && (tag_q[lookupIdx] == lookupTag);
    assign predict_taken  = hit && state_q[lookupIdx][1];
    assign predict_target = predict_taken ? target_q[lookupIdx] : (lookup_pc + XLEN'(4));

    assign updHit = valid_q[updIdx] && (tag_q[updIdx] == updTag);

    always_comb begin
        updWrite    = 1'b0;
        updState_d  = state_q[updIdx];
        updTarget_d = target_q[updIdx];
        if (upd_en) begin
            if (updHit) begin
                updWrite = 1'b1;
                if (upd_is_jump) begin
                    updState_d = STRONG_T;
                end else if (upd_taken) begin
                    unique case (state_q[updIdx])
                        STRONG_NT: updState_d = WEAK_NT;
                        WEAK_NT:   updState_d = WEAK_T;
                        WEAK_T:    updState_d = STRONG_T;
                        STRONG_T:  updState_d = STRONG_T;
                    endcase
                end else begin
                    unique case (state_q[updIdx])
                        STRONG_T:  updState_d = WEAK_T;
                        WEAK_T:    updState_d = WEAK_NT;
                        WEAK_NT:   updState_d = STRONG_NT;
                        STRONG_NT: updState_d = STRONG_NT;
                    endcase
                end
                if (upd_taken || upd_is_jump) begin
                    updTarget_d = upd_target;
                end
            end else if (upd_is_jump) begin
                updWrite    = 1'b1;
                updState_d  = STRONG_T;
                updTarget_d = upd_target;
            end else if (upd_taken) begin
                updWrite    = 1'b1;
                updState_d  = WEAK_T;
                updTarget_d = upd_target;
            end
        end
    end

    // Performance counters saturate at all-ones instead of wrapping.
    always_comb begin
        cntUpdates_d     = cntUpdates_q;
        cntMispredicts_d = cntMispredicts_q;
        if (upd_en && !(&cntUpdates_q)) begin
            cntUpdates_d = cntUpdates_q + CNT_W'(1);
        end
        if (upd_en && upd_mispredict && !(&cntMispredicts_q)) begin
            cntMispredicts_d = cntMispredicts_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q          <= '0;
            cntUpdates_q     <= '0;
            cntMispredicts_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                state_q[i]  <= STRONG_NT;
            end
        end else begin
            // Flush wins over a same-cycle table write; counters still advance.
            if (flush_all) begin
                valid_q <= '0;
            end else if (updWrite) begin
                valid_q[updIdx]  <= 1'b1;
                tag_q[updIdx]    <= updTag;
                target_q[updIdx] <= updTarget_d;
                state_q[updIdx]  <= updState_d;
            end
            cntUpdates_q     <= cntUpdates_d;
            cntMispredicts_q <= cntMispredicts_d;
        end
    end

    assign cnt_updates     = cntUpdates_q;
    assign cnt_mispredicts = cntMispredicts_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Vector-table bench for btb_predictor; a second CNT_W=4 instance shares stimulus to exercise counter saturation.
module tb_btb_predictor;

    typedef struct {
        logic        rst;
        logic [31:0] lookupPc;
        logic        updEn;
        logic [31:0] updPc;
        logic        updTaken;
        logic        updIsJump;
        logic [31:0] updTarget;
        logic        updMispredict;
        logic        flush;
        logic        expHit;
        logic        expTaken;
        logic [31:0] expTarget;
    } vec_t;

    typedef struct {
        int          id;
        logic        hit;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, upd_en, upd_taken, upd_is_jump, upd_mispredict, flush_all;
    logic [31:0] lookup_pc, upd_pc, upd_target;
    logic        hit, predict_taken, smallHit, smallTaken;
    logic [31:0] predict_target, smallTarget, cnt_updates, cnt_mispredicts;
    logic [3:0]  smallUpdates, smallMispredicts;

    int   testsRun = 0;
    int   failures = 0;
    int   expUpd   = 0;
    int   expMis   = 0;
    int   vecId    = 0;
    exp_t scoreboard[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    btb_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .hit(hit), .predict_taken(predict_taken),
        .predict_target(predict_target), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_is_jump(upd_is_jump), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush_all(flush_all), .cnt_updates(cnt_updates), .cnt_mispredicts(cnt_mispredicts)
    );

    btb_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(4)) dutSmall (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .hit(smallHit), .predict_taken(smallTaken),
        .predict_target(smallTarget), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_is_jump(upd_is_jump), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush_all(flush_all), .cnt_updates(smallUpdates), .cnt_mispredicts(smallMispredicts)
    );

    function automatic vec_t mkVec(logic r, logic [31:0] lpc, logic en, logic [31:0] upc, logic tk,
                                   logic jmp, logic [31:0] tgt, logic mis, logic fl,
                                   logic eh, logic et, logic [31:0] etg);
        vec_t v;
        v.rst = r; v.lookupPc = lpc; v.updEn = en; v.updPc = upc; v.updTaken = tk;
        v.updIsJump = jmp; v.updTarget = tgt; v.updMispredict = mis; v.flush = fl;
        v.expHit = eh; v.expTaken = et; v.expTarget = etg;
        return v;
    endfunction

    function automatic vec_t look(logic [31:0] lpc, logic eh, logic et, logic [31:0] etg);
        return mkVec(1'b0, lpc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, eh, et, etg);
    endfunction

    task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus just after the edge and queue what the lookup must show.
    task automatic applyStimulus(vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        rst = v.rst; lookup_pc = v.lookupPc; upd_en = v.updEn; upd_pc = v.updPc;
        upd_taken = v.updTaken; upd_is_jump = v.updIsJump; upd_target = v.updTarget;
        upd_mispredict = v.updMispredict; flush_all = v.flush;
        e.id = vecId; e.hit = v.expHit; e.taken = v.expTaken; e.target = v.expTarget;
        scoreboard.push_back(e);
        vecId++;
        if (v.rst) begin
            expUpd = 0;
            expMis = 0;
        end else if (v.updEn) begin
            expUpd++;
            if (v.updMispredict) expMis++;
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        @(negedge clk);
        testsRun++;
        if (scoreboard.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            testsRun--;
            e = scoreboard.pop_front();
            checkVal($sformatf("vec%0d hit", e.id), {31'b0, hit}, {31'b0, e.hit});
            checkVal($sformatf("vec%0d predict_taken", e.id), {31'b0, predict_taken}, {31'b0, e.taken});
            checkVal($sformatf("vec%0d predict_target", e.id), predict_target, e.target);
        end
    endtask

    task automatic checkCounters(string tag);
        checkVal({tag, " cnt_updates"}, cnt_updates, expUpd);
        checkVal({tag, " cnt_mispredicts"}, cnt_mispredicts, expMis);
        checkVal({tag, " small cnt_updates"}, {28'b0, smallUpdates}, (expUpd > 15) ? 15 : expUpd);
        checkVal({tag, " small cnt_mispredicts"}, {28'b0, smallMispredicts}, (expMis > 15) ? 15 : expMis);
    endtask

    task automatic runVec(vec_t v);
        applyStimulus(v);
        checkOutput();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; lookup_pc = 32'h0; upd_en = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
        upd_is_jump = 1'b0; upd_target = 32'h0; upd_mispredict = 1'b0; flush_all = 1'b0;

        // Training, hysteresis, aliasing, jump forcing, wraparound and flush-with-update.
        vecs.push_back(look(32'h100, 0, 0, 32'h104));
        vecs.push_back(mkVec(0, 32'h100, 1, 32'h100, 1, 0, 32'h80, 1, 0, 0, 0, 32'h104));
        vecs.push_back(look(32'h100, 1, 1, 32'h80));
        vecs.push_back(mkVec(0, 32'h100, 1, 32'h100, 0, 0, 32'h0, 1, 0, 1, 1, 32'h80));
        vecs.push_back(look(32'h100, 1, 0, 32'h104));
        vecs.push_back(mkVec(0, 32'h100, 1, 32'h100, 1, 0, 32'h80, 1, 0, 1, 0, 32'h104));
        vecs.push_back(mkVec(0, 32'h100, 1, 32'h100, 1, 0, 32'h80, 0, 0, 1, 1, 32'h80));
        vecs.push_back(mkVec(0, 32'h100, 1, 32'h100, 0, 0, 32'h0, 1, 0, 1, 1, 32'h80));
        vecs.push_back(look(32'h100, 1, 1, 32'h80));
        vecs.push_back(mkVec(0, 32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 0, 1, 1, 32'h80));
        vecs.push_back(look(32'h100, 1, 0, 32'h104));
        vecs.push_back(mkVec(0, 32'h140, 1, 32'h140, 1, 1, 32'h200, 0, 0, 0, 0, 32'h144));
        vecs.push_back(look(32'h100, 0, 0, 32'h104));
        vecs.push_back(look(32'h140, 1, 1, 32'h200));
        vecs.push_back(mkVec(0, 32'h300, 1, 32'h300, 0, 0, 32'h0, 0, 0, 0, 0, 32'h304));
        vecs.push_back(look(32'h300, 0, 0, 32'h304));
        vecs.push_back(look(32'h140, 1, 1, 32'h200));
        vecs.push_back(mkVec(0, 32'h140, 1, 32'h140, 0, 0, 32'h0, 0, 0, 1, 1, 32'h200));
        vecs.push_back(mkVec(0, 32'h140, 1, 32'h140, 0, 0, 32'h0, 1, 0, 1, 1, 32'h200));
        vecs.push_back(mkVec(0, 32'h140, 1, 32'h140, 1, 1, 32'h240, 1, 0, 1, 0, 32'h144));
        vecs.push_back(mkVec(0, 32'h140, 1, 32'h140, 0, 0, 32'h0, 0, 0, 1, 1, 32'h240));
        vecs.push_back(look(32'h140, 1, 1, 32'h240));
        vecs.push_back(look(32'hFFFF_FFFC, 0, 0, 32'h0));
        vecs.push_back(mkVec(0, 32'h104, 1, 32'h104, 1, 1, 32'h400, 0, 0, 0, 0, 32'h108));
        vecs.push_back(look(32'h104, 1, 1, 32'h400));
        vecs.push_back(look(32'h106, 1, 1, 32'h400));
        vecs.push_back(mkVec(0, 32'h140, 1, 32'h500, 1, 1, 32'h600, 1, 1, 1, 1, 32'h240));
        vecs.push_back(look(32'h140, 0, 0, 32'h144));
        vecs.push_back(look(32'h104, 0, 0, 32'h108));
        vecs.push_back(look(32'h500, 0, 0, 32'h504));

        repeat (3) @(posedge clk);
        runVec(mkVec(0, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h104));
        checkCounters("after reset");

        foreach (vecs[i]) runVec(vecs[i]);
        checkCounters("after table");

        // Reset overrides an update and a flush in the same cycle.
        runVec(mkVec(0, 32'h100, 1, 32'h100, 1, 1, 32'h80, 0, 0, 0, 0, 32'h104));
        runVec(look(32'h100, 1, 1, 32'h80));
        runVec(mkVec(1, 32'h100, 1, 32'h104, 1, 1, 32'h300, 1, 1, 1, 1, 32'h80));
        runVec(look(32'h104, 0, 0, 32'h108));
        runVec(look(32'h100, 0, 0, 32'h104));
        checkCounters("after mid reset");

        // Mispredicting jumps drive the 4-bit counters to saturation.
        for (int n = 0; n < 14; n++) begin
            runVec(mkVec(0, 32'h0, 1, 32'h700, 1, 1, 32'h800, 1, 0, 0, 0, 32'h4));
        end
        runVec(look(32'h0, 0, 0, 32'h4));
        checkCounters("14 mispredicts");
        for (int n = 0; n < 6; n++) begin
            runVec(mkVec(0, 32'h0, 1, 32'h700, 1, 1, 32'h800, 1, 0, 0, 0, 32'h4));
        end
        runVec(look(32'h700, 1, 1, 32'h800));
        checkCounters("20 mispredicts");

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
